// File: rtl/dual_port_ram_pkg.sv
// Shared constants, lane type and address helper for the PE local data RAM.
// No logic, no latency.
// No flow control.
package dual_port_ram_pkg;

  localparam int BYTE_W = 8;
  localparam int DATA_W = 32;
  localparam int LANES  = DATA_W / BYTE_W;

  typedef logic [BYTE_W-1:0] lane_t;

  // Byte address -> word index. Aliases above msize, and drops the byte offset.
  function automatic logic [31:0] word_index(input logic [31:0] addr, input int unsigned msize);
    return (addr & (msize - 1)) >> 2;
  endfunction

endpackage

// File: rtl/dp_ram_lane.sv
// One byte lane of the RAM: true dual-port array, one write port per side.
// Read is combinational; the caller registers it, which gives read-first behaviour.
// No backpressure. When both ports write one word in one cycle, port B wins.
module dp_ram_lane
  import dual_port_ram_pkg::*;
#(
  parameter int DEPTH = 16384,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  lane_t         a_wdata,
  output lane_t         a_rdata,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  lane_t         b_wdata,
  output lane_t         b_rdata
);

  lane_t mem [DEPTH];

  assign a_rdata = mem[a_addr];
  assign b_rdata = mem[b_addr];

  // Port B is written last, so its value lands when both ports hit one word.
  always_ff @(posedge clock) begin
    if (a_we) mem[a_addr] <= a_wdata;
    if (b_we) mem[b_addr] <= b_wdata;
  end

endmodule

// File: rtl/dual_port_ram_be.sv
// Per-PE data RAM. Port A serves DMA and port B serves CPU MMIO. Byte strobes on writes.
// Read latency is 1 cycle. On a same-cycle write the read returns the old word.
// No backpressure. Every enabled access completes in its cycle.
module dual_port_ram_be
  import dual_port_ram_pkg::*;
#(
  parameter int MEMORY_WIDTH = 32,
  parameter int RAM_MSIZE    = 65536,
  parameter int ADDRESS      = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    a_enable_in,
  input  logic [MEMORY_WIDTH-1:0] a_addr_in,
  input  logic [MEMORY_WIDTH-1:0] a_data_in,
  input  logic [LANES-1:0]        a_wb_in,
  output logic [MEMORY_WIDTH-1:0] a_data_out,
  input  logic                    b_enable_in,
  input  logic [MEMORY_WIDTH-1:0] b_addr_in,
  input  logic [MEMORY_WIDTH-1:0] b_data_in,
  input  logic [LANES-1:0]        b_wb_in,
  output logic [MEMORY_WIDTH-1:0] b_data_out
);

  localparam int DEPTH = RAM_MSIZE / 4;
  localparam int AW    = $clog2(DEPTH);

  if (MEMORY_WIDTH != DATA_W) begin : g_bad_width
    $error("dual_port_ram_be: only MEMORY_WIDTH=32 is supported");
  end
  if (RAM_MSIZE < 8 || (RAM_MSIZE & (RAM_MSIZE - 1)) != 0) begin : g_bad_size
    $error("dual_port_ram_be: RAM_MSIZE must be a power of two >= 8");
  end
  if (ADDRESS < 0 || ADDRESS > 16'hFFFF) begin : g_bad_node
    $error("dual_port_ram_be: ADDRESS must fit in {y[15:8], x[7:0]}");
  end

  logic [AW-1:0]           a_word, b_word;
  logic                    a_wr_en, b_wr_en;
  logic [MEMORY_WIDTH-1:0] a_rd_word, b_rd_word;

  assign a_word = AW'(word_index(a_addr_in, RAM_MSIZE));
  assign b_word = AW'(word_index(b_addr_in, RAM_MSIZE));

  // Writes are held off while reset is low. The array itself is never cleared.
  assign a_wr_en = a_enable_in & reset;
  assign b_wr_en = b_enable_in & reset;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    dp_ram_lane #(.DEPTH(DEPTH), .AW(AW)) u_lane (
      .clock   (clock),
      .a_we    (a_wr_en & a_wb_in[i]),
      .a_addr  (a_word),
      .a_wdata (a_data_in[i*BYTE_W +: BYTE_W]),
      .a_rdata (a_rd_word[i*BYTE_W +: BYTE_W]),
      .b_we    (b_wr_en & b_wb_in[i]),
      .b_addr  (b_word),
      .b_wdata (b_data_in[i*BYTE_W +: BYTE_W]),
      .b_rdata (b_rd_word[i*BYTE_W +: BYTE_W])
    );
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_data_out <= '0;
      b_data_out <= '0;
    end else begin
      if (a_enable_in) a_data_out <= a_rd_word;
      if (b_enable_in) b_data_out <= b_rd_word;
    end
  end

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Scoreboard bench for dual_port_ram_be: directed cases, then randomized traffic
// checked against a word-array reference model.
module tb_dual_port_ram_be;

  localparam int MSIZE = 65536;
  localparam int NW    = 64;

  typedef struct packed {
    logic        care;
    logic [31:0] val;
  } exp_t;

  logic        clock, reset;
  logic        a_enable_in, b_enable_in;
  logic [31:0] a_addr_in, a_data_in, b_addr_in, b_data_in;
  logic [3:0]  a_wb_in, b_wb_in;
  logic [31:0] a_data_out, b_data_out;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mdl   [NW];
  logic [3:0]  known [NW];
  exp_t qa[$], qb[$];
  exp_t a_last, b_last;

  dual_port_ram_be #(.MEMORY_WIDTH(32), .RAM_MSIZE(MSIZE), .ADDRESS(0)) dut (
    .clock       (clock),
    .reset       (reset),
    .a_enable_in (a_enable_in),
    .a_addr_in   (a_addr_in),
    .a_data_in   (a_data_in),
    .a_wb_in     (a_wb_in),
    .a_data_out  (a_data_out),
    .b_enable_in (b_enable_in),
    .b_addr_in   (b_addr_in),
    .b_data_in   (b_data_in),
    .b_wb_in     (b_wb_in),
    .b_data_out  (b_data_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr % MSIZE) / 4);
  endfunction

  task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp_v);
    end
  endtask

  task automatic check_port(input int p, input logic en, input logic [31:0] act);
    exp_t  e;
    string nm;
    nm = (p == 0) ? "port_a" : "port_b";
    if (en) begin
      if ((p == 0 && qa.size() == 0) || (p == 1 && qb.size() == 0)) begin
        checks++;
        failures++;
        $display("FAIL %s_underflow actual=%h expected=<no pending read>", nm, act);
        return;
      end
      if (p == 0) begin e = qa.pop_front(); a_last = e; end
      else        begin e = qb.pop_front(); b_last = e; end
    end else begin
      e = (p == 0) ? a_last : b_last;
    end
    if (e.care) check_val({nm, en ? "_read" : "_hold"}, act, e.val);
  endtask

  // Monitor: the enable and reset seen at each rising edge decide what the output should show.
  always begin
    logic a_en_s, b_en_s, rst_s;
    @(posedge clock);
    a_en_s = a_enable_in;
    b_en_s = b_enable_in;
    rst_s  = reset;
    #1;
    if (!rst_s) begin
      check_val("port_a_in_reset", a_data_out, 32'h0);
      check_val("port_b_in_reset", b_data_out, 32'h0);
      a_last = '{1'b1, 32'h0};
      b_last = '{1'b1, 32'h0};
    end else begin
      check_port(0, a_en_s, a_data_out);
      check_port(1, b_en_s, b_data_out);
    end
  end

  // Drive one cycle. Push the expected reads and update the model, then wait for the next negedge.
  // xa/xb bit 32 replaces the model value with a known constant.
  task automatic access(input logic ae, input logic [31:0] aa, input logic [31:0] ad, input logic [3:0] aw,
                        input logic be, input logic [31:0] ba, input logic [31:0] bd, input logic [3:0] bw,
                        input logic [32:0] xa = '0, input logic [32:0] xb = '0);
    int wa, wb;
    a_enable_in = ae; a_addr_in = aa; a_data_in = ad; a_wb_in = aw;
    b_enable_in = be; b_addr_in = ba; b_data_in = bd; b_wb_in = bw;
    if (reset) begin
      wa = word_of(aa);
      wb = word_of(ba);
      if (ae) qa.push_back(xa[32] ? exp_t'({1'b1, xa[31:0]}) : exp_t'({&known[wa], mdl[wa]}));
      if (be) qb.push_back(xb[32] ? exp_t'({1'b1, xb[31:0]}) : exp_t'({&known[wb], mdl[wb]}));
      for (int i = 0; i < 4; i++) begin
        if (ae && aw[i]) begin mdl[wa][8*i +: 8] = ad[8*i +: 8]; known[wa][i] = 1'b1; end
      end
      for (int i = 0; i < 4; i++) begin
        if (be && bw[i]) begin mdl[wb][8*i +: 8] = bd[8*i +: 8]; known[wb][i] = 1'b1; end
      end
    end
    @(negedge clock);
  endtask

  task automatic idle();
    access(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  function automatic logic [32:0] X(input logic [31:0] v);
    return {1'b1, v};
  endfunction

  initial begin
    for (int i = 0; i < NW; i++) begin mdl[i] = '0; known[i] = '0; end
    a_last = '{1'b1, 32'h0};
    b_last = '{1'b1, 32'h0};
    reset = 1'b0;
    a_enable_in = 0; a_addr_in = 0; a_data_in = 0; a_wb_in = 0;
    b_enable_in = 0; b_addr_in = 0; b_data_in = 0; b_wb_in = 0;
    #3;
    check_val("por_a_zero", a_data_out, 32'h0);
    check_val("por_b_zero", b_data_out, 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    // Fill the exercised region so that later reads are fully defined.
    for (int w = 0; w < NW; w++) access(1'b1, w * 4, $urandom, 4'hF, 1'b0, 0, 0, 4'h0);

    // Write on A, read on B
    access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 0, 0, 4'h0);
    access(1'b0, 0, 0, 4'h0, 1'b1, 32'h10, 32'h0, 4'h0, 33'h0, X(32'hDEADBEEF));

    // Byte strobes
    access(1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, 0, 0, 4'h0);
    access(1'b0, 0, 0, 4'h0, 1'b1, 32'h20, 32'h00AA0000, 4'b0100);
    access(1'b1, 32'h20, 32'h0, 4'h0, 1'b0, 0, 0, 4'h0, X(32'h11AA3344));

    // Cross-port collision: both reads return the old word, and B wins lanes 0 and 1
    access(1'b1, 32'h30, 32'h0BADC0DE, 4'hF, 1'b0, 0, 0, 4'h0);
    access(1'b1, 32'h30, 32'hAAAAAAAA, 4'hF, 1'b1, 32'h30, 32'hBBBBBBBB, 4'b0011,
           X(32'h0BADC0DE), X(32'h0BADC0DE));
    access(1'b1, 32'h30, 0, 4'h0, 1'b1, 32'h30, 0, 4'h0, X(32'hAAAABBBB), X(32'hAAAABBBB));

    // Address wrap and byte-offset drop
    access(1'b1, 32'h4000_0000 + MSIZE + 32'h7, 32'h5A5A1234, 4'hF, 1'b0, 0, 0, 4'h0);
    access(1'b0, 0, 0, 4'h0, 1'b1, 32'h4, 32'h0, 4'h0, 33'h0, X(32'h5A5A1234));

    // With enable low and strobes set, the output holds and memory stays unchanged
    access(1'b1, 32'h20, 0, 4'h0, 1'b0, 0, 0, 4'h0, X(32'h11AA3344));
    access(1'b0, 32'h20, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h20, 32'hFFFFFFFF, 4'hF);
    access(1'b0, 0, 0, 4'h0, 1'b1, 32'h20, 0, 4'h0, 33'h0, X(32'h11AA3344));

    // Randomized traffic on a small word set, so collisions happen often
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] ra, rb;
      ra = ($urandom & 32'hFFFF_0000) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      rb = ($urandom & 32'hFFFF_0000) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      access($urandom_range(0, 3) != 0, ra, $urandom, 4'($urandom_range(0, 15)),
             $urandom_range(0, 3) != 0, rb, $urandom, 4'($urandom_range(0, 15)));
    end

    // Reset in the middle of traffic: outputs clear at once, and writes made during reset are dropped
    access(1'b1, 32'h14, 32'hCAFEF00D, 4'hF, 1'b0, 0, 0, 4'h0);
    access(1'b1, 32'h14, 0, 4'h0, 1'b1, 32'h14, 0, 4'h0, X(32'hCAFEF00D), X(32'hCAFEF00D));
    #2;
    reset = 1'b0;
    #1;
    check_val("async_clear_a", a_data_out, 32'h0);
    check_val("async_clear_b", b_data_out, 32'h0);
    @(negedge clock);
    for (int n = 0; n < 3; n++) access(1'b1, 32'h14, 32'h0, 4'hF, 1'b1, 32'h14, 32'h0, 4'hF);
    reset = 1'b1;
    access(1'b1, 32'h14, 0, 4'h0, 1'b1, 32'h14, 0, 4'h0, X(32'hCAFEF00D), X(32'hCAFEF00D));
    idle();
    idle();

    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      failures++;
      $display("FAIL drain pending_a=%0d pending_b=%0d expected=0", qa.size(), qb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
